// File: rtl/board_mem_arbiter_pkg.sv
// Shared constants for the board memory arbiter: piece codes,
// requester indices, FSM encoding and the starting layout.
package board_mem_arbiter_pkg;

   localparam logic [3:0] PC_EMPTY  = 4'd0;
   localparam logic [3:0] P0_PAWN   = 4'd1;
   localparam logic [3:0] P0_ROOK   = 4'd2;
   localparam logic [3:0] P0_KNIGHT = 4'd3;
   localparam logic [3:0] P0_BISHOP = 4'd4;
   localparam logic [3:0] P0_QUEEN  = 4'd5;
   localparam logic [3:0] P0_KING   = 4'd6;
   localparam logic [3:0] P1_PAWN   = 4'd7;
   localparam logic [3:0] P1_ROOK   = 4'd8;
   localparam logic [3:0] P1_KNIGHT = 4'd9;
   localparam logic [3:0] P1_BISHOP = 4'd10;
   localparam logic [3:0] P1_QUEEN  = 4'd11;
   localparam logic [3:0] P1_KING   = 4'd12;

   localparam logic [1:0] CTRL  = 2'd0;
   localparam logic [1:0] VALID = 2'd1;
   localparam logic [1:0] DPATH = 2'd2;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_IDLE,
      ST_OWNED
   } state_e;

   // Indexed as INIT_BOARD[y][x].
   typedef logic [0:7][0:7][3:0] board_t;

   localparam board_t INIT_BOARD = '{
      '{P0_ROOK, P0_KNIGHT, P0_BISHOP, P0_QUEEN,
        P0_KING, P0_BISHOP, P0_KNIGHT, P0_ROOK},
      '{8{P0_PAWN}},
      '{8{PC_EMPTY}},
      '{8{PC_EMPTY}},
      '{8{PC_EMPTY}},
      '{8{PC_EMPTY}},
      '{8{P1_PAWN}},
      '{P1_ROOK, P1_KNIGHT, P1_BISHOP, P1_QUEEN,
        P1_KING, P1_BISHOP, P1_KNIGHT, P1_ROOK}
   };

   // First requesting index found scanning upward from start, wrapping.
   function automatic logic [2:0] arb_pick(
      input logic [2:0] r,
      input logic [1:0] start
   );
      logic [2:0] g;
      logic [1:0] i;
      g = '0;
      i = start;
      for (int k = 0; k < 3; k++) begin
         if (g == '0 && r[i]) g[i] = 1'b1;
         i = (i == 2'd2) ? 2'd0 : i + 2'd1;
      end
      return g;
   endfunction

   function automatic logic [1:0] oh_idx(input logic [2:0] g);
      return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
   endfunction

endpackage

// File: rtl/board_ram.sv
// 64x4 single-port board store: synchronous write, registered read.
module board_ram (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       we,
   input  logic [5:0] addr,
   input  logic [3:0] wdata,
   output logic [3:0] rdata
);

   logic [3:0] mem [64];
   logic [3:0] rd_q;
   logic [3:0] rd_d;

   always_comb begin
      rd_d = rd_q;
      if (en && !we) rd_d = mem[addr];
   end

   always_ff @(posedge clk) begin
      if (en && we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_q <= '0;
      else       rd_q <= rd_d;
   end

   assign rdata = rd_q;

endmodule

// File: rtl/board_mem_arbiter.sv
// Three-way arbiter in front of the board RAM; fills the starting
// position after reset or init_start, then grants exclusive ownership.
module board_mem_arbiter
   import board_mem_arbiter_pkg::*;
#(
   parameter int RR = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        init_start,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [17:0] addr,
   input  logic [11:0] wdata,
   output logic [2:0]  gnt,
   output logic [2:0]  rvalid,
   output logic [3:0]  rdata,
   output logic        busy
);

   state_e     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [2:0] gnt_q, gnt_d;
   logic [1:0] last_q, last_d;
   logic       busy_q, busy_d;
   logic [2:0] rvalid_q, rvalid_d;

   logic       fill;
   logic       access;
   logic       sel_we;
   logic [5:0] sel_addr;
   logic [3:0] sel_wdata;
   logic [1:0] start;
   logic [2:0] win;

   logic       ram_en;
   logic       ram_we;
   logic [5:0] ram_addr;
   logic [3:0] ram_wdata;

   always_comb begin
      sel_we    = we[0];
      sel_addr  = addr[5:0];
      sel_wdata = wdata[3:0];
      case (last_q)
         VALID: begin
            sel_we    = we[1];
            sel_addr  = addr[11:6];
            sel_wdata = wdata[7:4];
         end
         DPATH: begin
            sel_we    = we[2];
            sel_addr  = addr[17:12];
            sel_wdata = wdata[11:8];
         end
         default: ;
      endcase
   end

   assign fill   = (state_q == ST_FILL);
   assign access = gnt_q[last_q] && req[last_q];

   // Reset gates the port so an in-flight write is dropped.
   assign ram_en    = !reset && (fill || access);
   assign ram_we    = fill || sel_we;
   assign ram_addr  = fill ? cnt_q : sel_addr;
   assign ram_wdata = fill ? INIT_BOARD[cnt_q[5:3]][cnt_q[2:0]]
                           : sel_wdata;

   always_comb begin
      start = 2'd0;
      if (RR != 0) start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      win = arb_pick(req, start);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      rvalid_d = (access && !sel_we) ? gnt_q : 3'b000;
      if (init_start) begin
         state_d = ST_FILL;
         cnt_d   = '0;
         gnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_FILL: begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd63) state_d = ST_IDLE;
            end
            ST_IDLE: begin
               if (win != '0) begin
                  gnt_d   = win;
                  last_d  = oh_idx(win);
                  state_d = ST_OWNED;
               end
            end
            ST_OWNED: begin
               // Owner's req is low here, so it cannot win itself.
               if (!req[last_q]) begin
                  gnt_d = win;
                  if (win != '0) last_d = oh_idx(win);
                  else           state_d = ST_IDLE;
               end
            end
            default: state_d = ST_FILL;
         endcase
      end
      busy_d = (state_d == ST_FILL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_FILL;
         cnt_q    <= '0;
         gnt_q    <= '0;
         last_q   <= DPATH;
         busy_q   <= 1'b1;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         rvalid_q <= rvalid_d;
      end
   end

   board_ram u_ram (
      .clk   (clk),
      .reset (reset),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (rdata)
   );

   assign gnt    = gnt_q;
   assign rvalid = rvalid_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench: u_rr runs round-robin, u_fp fixed priority;
// both share every input except req.
module tb_board_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        init_start;
   logic [2:0]  req_a, req_b;
   logic [2:0]  we;
   logic [17:0] addr;
   logic [11:0] wdata;
   logic [2:0]  gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [3:0]  rdata_a, rdata_b;
   logic        busy_a, busy_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   board_mem_arbiter #(.RR(1)) u_rr (
      .clk(clk), .reset(reset), .init_start(init_start),
      .req(req_a), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .busy(busy_a)
   );

   board_mem_arbiter #(.RR(0)) u_fp (
      .clk(clk), .reset(reset), .init_start(init_start),
      .req(req_b), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .busy(busy_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; init_start = 1'b0;
      req_a = '0; req_b = '0; we = '0; addr = '0; wdata = '0;
      step(); step();
      chk("rst_gnt", {5'd0, gnt_a}, 8'd0);
      chk("rst_rvalid", {5'd0, rvalid_a}, 8'd0);
      chk("rst_rdata", {4'd0, rdata_a}, 8'd0);
      chk("rst_busy", {7'd0, busy_a}, 8'd1);
      reset = 1'b0;

      req_a = 3'b001;
      for (int i = 0; i < 63; i++) step();
      chk("fill_busy63", {7'd0, busy_a}, 8'd1);
      chk("fill_gnt0", {5'd0, gnt_a}, 8'd0);
      req_a = 3'b000;
      step();
      chk("fill_busy64", {7'd0, busy_a}, 8'd0);

      req_a = 3'b001; addr[5:0] = 6'd4;
      step();
      chk("rd_gnt", {5'd0, gnt_a}, 8'd1);
      chk("rd_rv_early", {5'd0, rvalid_a}, 8'd0);
      step();
      chk("rd04_rv", {5'd0, rvalid_a}, 8'd1);
      chk("rd04", {4'd0, rdata_a}, 8'd6);
      addr[5:0] = 6'd59;
      step();
      chk("rd73", {4'd0, rdata_a}, 8'd11);
      addr[5:0] = 6'd36;
      step();
      chk("rd44", {4'd0, rdata_a}, 8'd0);

      we = 3'b001; wdata[3:0] = 4'd0; addr[5:0] = 6'd12;
      step();
      chk("wr_no_rv", {5'd0, rvalid_a}, 8'd0);
      we = 3'b000;
      step();
      chk("raw_rv", {5'd0, rvalid_a}, 8'd1);
      chk("raw_data", {4'd0, rdata_a}, 8'd0);
      req_a = 3'b000;
      step();
      chk("release", {5'd0, gnt_a}, 8'd0);

      req_a = 3'b010; addr[11:6] = 6'd0;
      step();
      chk("val_gnt", {5'd0, gnt_a}, 8'd2);
      req_a = 3'b011;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("val_hold", {5'd0, gnt_a}, 8'd2);
      end
      chk("val_rv", {5'd0, rvalid_a}, 8'd2);
      chk("val_rd", {4'd0, rdata_a}, 8'd2);
      req_a = 3'b001;
      step();
      chk("ctl_after", {5'd0, gnt_a}, 8'd1);
      chk("ctl_after_rv", {5'd0, rvalid_a}, 8'd0);

      req_a = 3'b111;
      step();
      chk("rr_hold0", {5'd0, gnt_a}, 8'd1);
      req_a = 3'b110;
      step();
      chk("rr_to1", {5'd0, gnt_a}, 8'd2);
      req_a = 3'b111;
      step();
      chk("rr_hold1", {5'd0, gnt_a}, 8'd2);
      req_a = 3'b101;
      step();
      chk("rr_to2", {5'd0, gnt_a}, 8'd4);
      req_a = 3'b111;
      step();
      req_a = 3'b011;
      step();
      chk("rr_to0", {5'd0, gnt_a}, 8'd1);

      req_a = 3'b100; addr[17:12] = 6'd59;
      step();
      chk("dp_gnt", {5'd0, gnt_a}, 8'd4);
      init_start = 1'b1;
      step();
      init_start = 1'b0; req_a = 3'b000;
      chk("init_gnt", {5'd0, gnt_a}, 8'd0);
      chk("init_busy", {7'd0, busy_a}, 8'd1);
      chk("init_rv", {5'd0, rvalid_a}, 8'd4);
      chk("init_rd", {4'd0, rdata_a}, 8'd11);
      for (int i = 0; i < 63; i++) step();
      chk("refill_busy", {7'd0, busy_a}, 8'd1);
      step();
      chk("refill_done", {7'd0, busy_a}, 8'd0);
      req_a = 3'b001; addr[5:0] = 6'd12;
      step(); step();
      chk("restored14", {4'd0, rdata_a}, 8'd1);
      addr[5:0] = 6'd63;
      step();
      chk("restored77", {4'd0, rdata_a}, 8'd8);
      req_a = 3'b000;

      req_b = 3'b110;
      step();
      chk("fp_gnt1", {5'd0, gnt_b}, 8'd2);
      step(); step(); step();
      chk("fp_hold1", {5'd0, gnt_b}, 8'd2);
      req_b = 3'b111;
      step();
      chk("fp_hold_all", {5'd0, gnt_b}, 8'd2);
      req_b = 3'b101;
      step();
      chk("fp_to0", {5'd0, gnt_b}, 8'd1);

      step();
      reset = 1'b1;
      step();
      chk("rst2_gnt", {5'd0, gnt_b}, 8'd0);
      chk("rst2_busy", {7'd0, busy_b}, 8'd1);
      chk("rst2_rv", {5'd0, rvalid_b}, 8'd0);
      chk("rst2_rd", {4'd0, rdata_b}, 8'd0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
